// File: rtl/seg_display_driver.sv
// Four-digit MM:SS driver for a common-anode 7-segment display. Inputs are snapshotted once per frame.
// Outputs are registered and follow the digit index one clock later. There is no backpressure.
module seg_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       swADJ,
    input  logic       swSEL,
    output logic [7:0] seg,
    output logic [3:0] an
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_q, refresh_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          hidden_q, hidden_d;
    logic [1:0]    idx_q, idx_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          tick, blink_wrap, blank;
    logic [3:0]    digit;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if      (v >= 6'd60) return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    // Remainder is below 10, so modulo-16 arithmetic on the low nibble is exact.
    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return v[3:0] - (tens_of(v) * 4'd10);
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        tick       = (refresh_q == REFRESH_LAST);
        blink_wrap = (blink_q == BLINK_LAST);
        refresh_d  = tick ? '0 : refresh_q + 1'b1;
        blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
        hidden_d   = blink_wrap ? ~hidden_q : hidden_q;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        min_d      = min_q;
        sec_d      = sec_q;
        if (tick && idx_q == 2'd3) begin
            min_d = minutes;
            sec_d = seconds;
        end

        case (idx_q)
            2'd0:    digit = ones_of(sec_q);
            2'd1:    digit = tens_of(sec_q);
            2'd2:    digit = ones_of(min_q);
            default: digit = tens_of(min_q);
        endcase

        // Seconds pair lives on indices 0/1 (idx[1]=0), minutes pair on 2/3.
        blank = swADJ && hidden_q && (swSEL ? ~idx_q[1] : idx_q[1]);
        an_d  = 4'hF;
        seg_d = 8'hFF;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg7(digit) & ((idx_q == 2'd2) ? 8'h7F : 8'hFF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            blink_q   <= '0;
            hidden_q  <= 1'b0;
            idx_q     <= 2'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            seg_q     <= 8'hFF;
            an_q      <= 4'hF;
        end else begin
            refresh_q <= refresh_d;
            blink_q   <= blink_d;
            hidden_q  <= hidden_d;
            idx_q     <= idx_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV=4, BLINK_DIV=32 (16-cycle frames, 32-cycle blink phases).
module tb_seg_display_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes, seconds;
    logic       swADJ, swSEL;
    logic [7:0] seg;
    logic [3:0] an;

    int n_vec = 0;
    int n_err = 0;
    int pos   = 0;

    always #5 clk = ~clk;

    seg_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(32)) dut (
        .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
        .swADJ(swADJ), .swSEL(swSEL), .seg(seg), .an(an)
    );

    typedef struct {
        logic [5:0]  mins;
        logic [5:0]  secs;
        logic        adj;
        logic        sel;
        int          frame;
        logic [31:0] segs;  // {slot3, slot2, slot1, slot0}
        logic [15:0] ans;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        n_vec++;
        if (an !== exp_an || seg !== exp_seg) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h", name, an, seg, exp_an, exp_seg);
        end
    endtask

    // Edge k = k-th posedge after reset release; sampling happens on the following negedge.
    task automatic goto(input int k);
        repeat (k - pos) @(posedge clk);
        @(negedge clk);
        pos = k;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
    endtask

    function automatic vec_t mk(input logic [5:0] m, input logic [5:0] s, input logic a, input logic l,
                                input int f, input logic [31:0] sg, input logic [15:0] anv);
        vec_t v;
        v.mins = m; v.secs = s; v.adj = a; v.sel = l; v.frame = f; v.segs = sg; v.ans = anv;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(6'd12, 6'd34, 1'b0, 1'b0, 1, 32'hF9_24_B0_99, 16'b0111_1011_1101_1110);
        vecs[1] = mk(6'd5,  6'd7,  1'b1, 1'b1, 2, 32'hC0_12_FF_FF, 16'b0111_1011_1111_1111);
        vecs[2] = mk(6'd5,  6'd7,  1'b1, 1'b1, 1, 32'hC0_12_C0_F8, 16'b0111_1011_1101_1110);
        vecs[3] = mk(6'd5,  6'd7,  1'b1, 1'b0, 2, 32'hFF_FF_C0_F8, 16'b1111_1111_1101_1110);
        vecs[4] = mk(6'd63, 6'd60, 1'b0, 1'b0, 1, 32'h82_30_82_C0, 16'b0111_1011_1101_1110);
        vecs[5] = mk(6'd59, 6'd9,  1'b0, 1'b0, 1, 32'h92_10_C0_90, 16'b0111_1011_1101_1110);
        vecs[6] = mk(6'd48, 6'd21, 1'b0, 1'b0, 1, 32'h99_00_A4_F9, 16'b0111_1011_1101_1110);
        vecs[7] = mk(6'd5,  6'd7,  1'b0, 1'b1, 2, 32'hC0_12_C0_F8, 16'b0111_1011_1101_1110);

        rst = 1'b1; minutes = 6'd12; seconds = 6'd34; swADJ = 1'b0; swSEL = 1'b0;

        // Reset hold, release, and the 00:00 first frame
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 4'b1111, 8'hFF);
        rst = 1'b0;
        pos = 0;
        goto(1);  check("post_reset_slot0", 4'b1110, 8'hC0);
        goto(9);  check("first_frame_colon", 4'b1011, 8'h40);
        goto(13); check("first_frame_slot3", 4'b0111, 8'hC0);
        goto(17); check("second_frame_slot0", 4'b1110, 8'h99);

        foreach (vecs[i]) begin
            int f;
            minutes = vecs[i].mins; seconds = vecs[i].secs;
            swADJ = vecs[i].adj; swSEL = vecs[i].sel;
            reset_dut();
            f = (vecs[i].frame == 1) ? 17 : 33;
            for (int s = 0; s < 4; s++) begin
                goto(f + 4 * s + 1);
                check($sformatf("vec%0d_slot%0d_first", i, s), vecs[i].ans[4*s +: 4], vecs[i].segs[8*s +: 8]);
                goto(f + 4 * s + 3);
                check($sformatf("vec%0d_slot%0d_last", i, s), vecs[i].ans[4*s +: 4], vecs[i].segs[8*s +: 8]);
            end
        end

        // Input change mid-frame must not tear the current frame
        minutes = 6'd12; seconds = 6'd34; swADJ = 1'b0; swSEL = 1'b0;
        reset_dut();
        goto(21); check("tear_slot1_before", 4'b1101, 8'hB0);
        seconds = 6'd35;
        goto(24); check("tear_slot1_after", 4'b1101, 8'hB0);
        goto(25); check("tear_slot2", 4'b1011, 8'h24);
        goto(29); check("tear_slot3", 4'b0111, 8'hF9);
        goto(33); check("tear_next_frame_slot0", 4'b1110, 8'h92);
        goto(37); check("tear_next_frame_slot1", 4'b1101, 8'hB0);

        // swADJ change applies on the very next output register update
        minutes = 6'd5; seconds = 6'd7; swADJ = 1'b1; swSEL = 1'b1;
        reset_dut();
        goto(33); check("adj_hidden", 4'b1111, 8'hFF);
        swADJ = 1'b0;
        goto(34); check("adj_off_shows", 4'b1110, 8'hF8);
        swADJ = 1'b1;
        goto(35); check("adj_on_blanks", 4'b1111, 8'hFF);
        goto(65); check("phase_visible_again", 4'b1110, 8'hF8);

        // Reset mid-frame while index 2 is displayed
        minutes = 6'd12; seconds = 6'd34; swADJ = 1'b0; swSEL = 1'b0;
        reset_dut();
        goto(25); check("midrst_before", 4'b1011, 8'h24);
        rst = 1'b1;
        goto(26); check("midrst_asserted", 4'b1111, 8'hFF);
        rst = 1'b0;
        pos = 0;
        goto(1);  check("midrst_restart_slot0", 4'b1110, 8'hC0);
        goto(9);  check("midrst_restart_colon", 4'b1011, 8'h40);
        goto(17); check("midrst_new_frame", 4'b1110, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
